// File: rtl/apb_bridge_pkg.sv
// Shared types, address map and response codes for the AHB-to-APB bridge.
// Pure declarations: no latency, no flow control.
// Holds the slave-region decode used by apb_master_ctrl.
package apb_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WWAIT,
    SETUP,
    ACCESS,
    ERR
  } state_t;

  localparam logic [31:0] BRIDGE_BASE = 32'h8000_0000;
  localparam logic [31:0] REGION_SIZE = 32'h0400_0000;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // True when addr falls inside slave idx's window; widened to 64 bits so the
  // upper region bound cannot wrap.
  function automatic logic decode(input logic [63:0] addr, input int idx);
    logic [63:0] lo;
    lo = 64'(BRIDGE_BASE) + 64'(idx) * 64'(REGION_SIZE);
    return (addr >= lo) && (addr < (lo + 64'(REGION_SIZE)));
  endfunction

endpackage

// File: rtl/apb_master_ctrl.sv
// APB-side sequencer of the AHB-to-APB bridge; optional APB_PREADY_EN adds pready/pslverr.
// Latency: read 2, write 3 hreadyout-low cycles (+1 per pready=0 cycle, +1 on error).
// Backpressure: one transfer in flight; hreadyout=0 stalls the AHB master until completion.
module apb_master_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 3
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              valid,
  input  logic [ADDR_W-1:0] haddr,
  input  logic              hwrite,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] prdata,
`ifdef APB_PREADY_EN
  input  logic              pready,
  input  logic              pslverr,
`endif
  output logic               hreadyout,
  output logic [1:0]         hresp,
  output logic [DATA_W-1:0]  hrdata,
  output logic [NUM_SLV-1:0] psel,
  output logic               penable,
  output logic               pwrite,
  output logic [ADDR_W-1:0]  paddr,
  output logic [DATA_W-1:0]  pwdata
);
  import apb_bridge_pkg::*;

  state_t               state, state_nxt;
  logic                 hreadyout_nxt;
  logic [1:0]           hresp_nxt;
  logic [DATA_W-1:0]    hrdata_nxt;
  logic [NUM_SLV-1:0]   psel_nxt;
  logic                 penable_nxt;
  logic                 pwrite_nxt;
  logic [ADDR_W-1:0]    paddr_nxt;
  logic [DATA_W-1:0]    pwdata_nxt;
  logic [NUM_SLV-1:0]   dec_haddr, dec_paddr;
  logic                 access_done;

`ifdef APB_PREADY_EN
  assign access_done = pready;
`else
  assign access_done = 1'b1;
`endif

  always_comb begin
    dec_haddr = '0;
    dec_paddr = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      dec_haddr[i] = decode(64'(haddr), i);
      dec_paddr[i] = decode(64'(paddr), i);
    end
  end

  always_comb begin
    state_nxt     = state;
    hreadyout_nxt = hreadyout;
    hresp_nxt     = hresp;
    hrdata_nxt    = hrdata;
    psel_nxt      = psel;
    penable_nxt   = penable;
    pwrite_nxt    = pwrite;
    paddr_nxt     = paddr;
    pwdata_nxt    = pwdata;
    case (state)
      IDLE: begin
        // An IDLE cycle still showing ERROR is the second error cycle: valid is ignored.
        if (valid && hreadyout && (hresp == HRESP_OKAY)) begin
          paddr_nxt     = haddr;
          pwrite_nxt    = hwrite;
          hreadyout_nxt = 1'b0;
          if (hwrite) begin
            state_nxt = WWAIT;
          end else begin
            state_nxt = SETUP;
            psel_nxt  = dec_haddr;
          end
        end else begin
          hresp_nxt = HRESP_OKAY;
        end
      end
      WWAIT: begin
        state_nxt  = SETUP;
        pwdata_nxt = hwdata;
        psel_nxt   = dec_paddr;
      end
      SETUP: begin
        state_nxt   = ACCESS;
        penable_nxt = 1'b1;
      end
      ACCESS: begin
        if (access_done) begin
          psel_nxt    = '0;
          penable_nxt = 1'b0;
`ifdef APB_PREADY_EN
          if (pslverr) begin
            state_nxt = ERR;
            hresp_nxt = HRESP_ERROR;
          end else
`endif
          begin
            state_nxt     = IDLE;
            hreadyout_nxt = 1'b1;
            if (!pwrite) hrdata_nxt = prdata;
          end
        end
      end
`ifdef APB_PREADY_EN
      ERR: begin
        state_nxt     = IDLE;
        hreadyout_nxt = 1'b1;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= IDLE;
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
      hrdata    <= '0;
      psel      <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
    end else begin
      state     <= state_nxt;
      hreadyout <= hreadyout_nxt;
      hresp     <= hresp_nxt;
      hrdata    <= hrdata_nxt;
      psel      <= psel_nxt;
      penable   <= penable_nxt;
      pwrite    <= pwrite_nxt;
      paddr     <= paddr_nxt;
      pwdata    <= pwdata_nxt;
    end
  end

endmodule
